frame_seq_ctrl: RTL and testbench

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

---
 rtl/frame_seq_pkg.sv | 23 ++
 rtl/hdr_beat_counter.sv | 37 +++
 rtl/frame_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_frame_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared FSM state type and beat/header geometry helpers for the frame sequencer.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        DROP
    } state_t;

    function automatic int calc_bpb(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int calc_hdr_beats(input int header_bytes, input int bpb);
        return (header_bytes + bpb - 1) / bpb;
    endfunction

    function automatic int calc_split(input int header_bytes, input int bpb);
        return header_bytes % bpb;
    endfunction

endpackage

// File: rtl/hdr_beat_counter.sv
// Tracks the beat index within the header region and flags the header/payload boundary beat.
module hdr_beat_counter #(
    parameter int HDR_BEATS = 3,
    parameter int HIW       = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_start,
    input  logic           beat_accept,
    input  logic           abort,
    input  logic           hdr_busy,
    input  logic           idle_valid,
    output logic           in_header,
    output logic           header_done,
    output logic           at_boundary,
    output logic [HIW-1:0] hdr_idx
);

    logic [HIW-1:0] idx_q;

    assign at_boundary = (idx_q == HIW'(HDR_BEATS - 1));
    assign header_done = beat_accept && at_boundary;
    assign in_header   = idle_valid || hdr_busy;
    assign hdr_idx     = idx_q;

    // Index returns to zero whenever the header region is left, so IDLE always presents beat 0.
    always_ff @(posedge clk) begin
        if (rst || abort || header_done) begin
            idx_q <= '0;
        end else if (frame_start) begin
            idx_q <= HIW'(1);
        end else if (beat_accept) begin
            idx_q <= idx_q + HIW'(1);
        end
    end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Zero-latency frame splitter: routes header beats and payload beats to separate sinks.
// Optional statistics counters are built when FRAME_SEQ_STATS_EN is defined.
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter int  DATA_WIDTH      = 64,
    parameter int  HEADER_BYTES    = 18,
    parameter int  MAX_FRAME_BYTES = 1522,
    localparam int BPB             = calc_bpb(DATA_WIDTH),
    localparam int HDR_BEATS       = calc_hdr_beats(HEADER_BYTES, BPB),
    localparam int SPLIT           = calc_split(HEADER_BYTES, BPB),
    localparam int HIW             = $clog2(HDR_BEATS + 1),
    localparam int OW              = $clog2(BPB) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [DATA_WIDTH-1:0] hdr_data,
    output logic [HIW-1:0]        hdr_idx,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [OW-1:0]         m_offs,
    output logic                  frame_start,
    output logic                  header_done,
    output logic                  in_header,
    output logic                  err_runt,
    output logic                  err_oversize,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_drops
);

    localparam int          CW   = $clog2(MAX_FRAME_BYTES + 2 * BPB);
    localparam logic [CW:0] SAT  = (CW + 1)'(MAX_FRAME_BYTES + BPB);
    localparam logic [CW:0] MAXV = (CW + 1)'(MAX_FRAME_BYTES);

    state_t        state, state_nxt;
    logic [CW-1:0] byte_cnt, byte_cnt_nxt;
    logic [CW:0]   byte_sum;
    logic          hdr_phase, at_boundary, oversize, accept;
    logic          beat_accept, abort;

    assign byte_sum  = {1'b0, byte_cnt} + (CW + 1)'(BPB);
    assign hdr_phase = (state == IDLE) || (state == HDR);
    assign oversize  = s_valid && (state != DROP) && !s_last && (byte_sum > MAXV);
    assign hdr_data  = s_data;
    assign m_data    = s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    // Handshakes are held off while rst is high so a frame caught by reset ends without any pulse.
    always_comb begin
        s_ready      = 1'b0;
        hdr_valid    = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        m_offs       = '0;
        frame_start  = 1'b0;
        err_runt     = 1'b0;
        err_oversize = 1'b0;
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        if (!rst) begin
            case (state)
                IDLE, HDR: begin
                    if (oversize) begin
                        s_ready = 1'b1;
                    end else begin
                        hdr_valid = s_valid;
                        s_ready   = hdr_ready;
                        if (at_boundary && (SPLIT != 0)) begin
                            m_valid = s_valid;
                            s_ready = hdr_ready && m_ready;
                            m_offs  = OW'(SPLIT);
                            m_last  = s_last;
                        end
                    end
                end
                PAY: begin
                    if (oversize) begin
                        s_ready = 1'b1;
                    end else begin
                        m_valid = s_valid;
                        s_ready = m_ready;
                        m_last  = s_last;
                    end
                end
                DROP:    s_ready = 1'b1;
                default: s_ready = 1'b0;
            endcase
        end
        accept = s_valid && s_ready;
        if (accept) begin
            byte_cnt_nxt = (byte_sum > SAT) ? SAT[CW-1:0] : byte_sum[CW-1:0];
            case (state)
                IDLE, HDR: begin
                    frame_start = (state == IDLE);
                    if (oversize) begin
                        err_oversize = 1'b1;
                        state_nxt    = DROP;
                    end else if (at_boundary) begin
                        state_nxt = s_last ? IDLE : PAY;
                    end else if (s_last) begin
                        err_runt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HDR;
                    end
                end
                PAY: begin
                    if (oversize) begin
                        err_oversize = 1'b1;
                        state_nxt    = DROP;
                    end else if (s_last) begin
                        state_nxt = IDLE;
                    end
                end
                DROP:    if (s_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
            if (state_nxt == IDLE) byte_cnt_nxt = '0;
        end
        beat_accept = accept && hdr_phase && !oversize;
        abort       = accept && hdr_phase && (oversize || err_runt);
    end

    hdr_beat_counter #(
        .HDR_BEATS (HDR_BEATS),
        .HIW       (HIW)
    ) u_hdr_beat_counter (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .beat_accept (beat_accept),
        .abort       (abort),
        .hdr_busy    ((state == HDR) && !rst),
        .idle_valid  ((state == IDLE) && s_valid && !rst),
        .in_header   (in_header),
        .header_done (header_done),
        .at_boundary (at_boundary),
        .hdr_idx     (hdr_idx)
    );

`ifdef FRAME_SEQ_STATS_EN
    logic [31:0] frames_q, drops_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            if (frame_start && (frames_q != '1)) frames_q <= frames_q + 32'd1;
            if ((err_runt || err_oversize) && (drops_q != '1)) drops_q <= drops_q + 32'd1;
        end
    end

    assign stat_frames = frames_q;
    assign stat_drops  = drops_q;
`else
    assign stat_frames = '0;
    assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Randomized self-checking bench for frame_seq_ctrl against a per-beat rule model.
module tb_frame_seq_ctrl;

    localparam int DW     = 64;
    localparam int HB     = 18;
    localparam int MAXB   = 64;
    localparam int BPB    = DW / 8;
    localparam int HBEATS = (HB + BPB - 1) / BPB;
    localparam int SPLIT  = HB % BPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic          hdr_valid, hdr_ready;
    logic [DW-1:0] hdr_data;
    logic [1:0]    hdr_idx;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic [3:0]    m_offs;
    logic          frame_start, header_done, in_header, err_runt, err_oversize;
    logic [31:0]   stat_frames, stat_drops;

    int checks = 0;
    int errors = 0;
    int expFrames = 0;
    int expDrops = 0;

    always #5 clk = ~clk;

    frame_seq_ctrl #(
        .DATA_WIDTH      (DW),
        .HEADER_BYTES    (HB),
        .MAX_FRAME_BYTES (MAXB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .hdr_valid    (hdr_valid),
        .hdr_ready    (hdr_ready),
        .hdr_data     (hdr_data),
        .hdr_idx      (hdr_idx),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_offs       (m_offs),
        .frame_start  (frame_start),
        .header_done  (header_done),
        .in_header    (in_header),
        .err_runt     (err_runt),
        .err_oversize (err_oversize),
        .stat_frames  (stat_frames),
        .stat_drops   (stat_drops)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l,
                                 input logic hr, input logic mr);
        s_valid   = v;
        s_data    = d;
        s_last    = l;
        hdr_ready = hr;
        m_ready   = mr;
    endtask

    // Model: beat k of an n-beat frame is header if k < HBEATS, the boundary beat also
    // carries payload when SPLIT != 0, and a non-final beat taking the frame past MAXB is dropped.
    task automatic checkBeat(input int k, input int n, input bit dropped, input logic [DW-1:0] d,
                             input logic hr, input logic mr, output bit acc, output bit ovs);
        bit last, bnd, hv, mv, rdy, inHdr;
        last  = (k == n - 1);
        bnd   = (k == HBEATS - 1);
        ovs   = !dropped && ((k + 1) * BPB > MAXB) && !last;
        inHdr = !dropped && (k < HBEATS);
        hv    = !dropped && !ovs && (k < HBEATS);
        mv    = !dropped && !ovs && ((k >= HBEATS) || (bnd && SPLIT != 0));
        if (dropped || ovs) rdy = 1'b1;
        else rdy = (hv ? hr : 1'b1) && (mv ? mr : 1'b1);
        acc = rdy;
        @(negedge clk);
        checkOutput("s_ready", s_ready, rdy);
        checkOutput("hdr_valid", hdr_valid, hv);
        checkOutput("m_valid", m_valid, mv);
        checkOutput("in_header", in_header, inHdr);
        checkOutput("hdr_idx", hdr_idx, inHdr ? k : 0);
        checkOutput("frame_start", frame_start, acc && (k == 0));
        checkOutput("header_done", header_done, acc && hv && bnd);
        checkOutput("err_runt", err_runt, acc && hv && last && (k < HBEATS - 1));
        checkOutput("err_oversize", err_oversize, acc && ovs);
        if (hv) checkOutput("hdr_data", hdr_data, d);
        if (mv) begin
            checkOutput("m_data", m_data, d);
            checkOutput("m_offs", m_offs, (k < HBEATS) ? SPLIT : 0);
            checkOutput("m_last", m_last, last);
        end
    endtask

    task automatic checkIdle(input int k, input bit dropped);
        bit inHdr;
        inHdr = !dropped && (k > 0) && (k < HBEATS);
        @(negedge clk);
        checkOutput("idle_hdr_valid", hdr_valid, 0);
        checkOutput("idle_m_valid", m_valid, 0);
        checkOutput("idle_in_header", in_header, inHdr);
        checkOutput("idle_hdr_idx", hdr_idx, inHdr ? k : 0);
        checkOutput("idle_frame_start", frame_start, 0);
        checkOutput("idle_header_done", header_done, 0);
    endtask

    task automatic checkStats();
        @(negedge clk);
`ifdef FRAME_SEQ_STATS_EN
        checkOutput("stat_frames", stat_frames, expFrames);
        checkOutput("stat_drops", stat_drops, expDrops);
`else
        checkOutput("stat_frames", stat_frames, 0);
        checkOutput("stat_drops", stat_drops, 0);
`endif
    endtask

    // mode 0: random readies and gaps, 1: all ready, 2: m_ready low on first try of each beat.
    task automatic sendFrame(input int n, input int mode, input int rstBeat);
        bit dropped, acc, ovs;
        logic [DW-1:0] data;
        logic hr, mr;
        dropped = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (mode == 0 && $urandom_range(3) == 0) begin
                applyStimulus(1'b0, {$urandom, $urandom}, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
                checkIdle(k, dropped);
                @(posedge clk); #1;
            end
            data = {$urandom, $urandom};
            if (k == rstBeat) begin
                applyStimulus(1'b1, data, k == n - 1, 1'b1, 1'b1);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("rst_s_ready", s_ready, 0);
                checkOutput("rst_m_valid", m_valid, 0);
                checkOutput("rst_m_last", m_last, 0);
                checkOutput("rst_err", {err_runt, err_oversize}, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                expFrames = 0;
                expDrops  = 0;
                applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
                checkIdle(0, 1'b0);
                checkStats();
                @(posedge clk); #1;
                return;
            end
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                if (mode == 1 || t >= 6) begin
                    hr = 1'b1; mr = 1'b1;
                end else if (mode == 2) begin
                    hr = 1'b1; mr = (t != 0);
                end else begin
                    hr = 1'($urandom_range(1)); mr = 1'($urandom_range(1));
                end
                applyStimulus(1'b1, data, k == n - 1, hr, mr);
                checkBeat(k, n, dropped, data, hr, mr, acc, ovs);
                @(posedge clk); #1;
            end
            if (k == 0) expFrames++;
            if (ovs) begin
                dropped = 1'b1;
                expDrops++;
            end
            if (!dropped && k == n - 1 && k < HBEATS - 1) expDrops++;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkStats();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_s_ready", s_ready, 0);
        checkOutput("reset_in_header", in_header, 0);
        checkOutput("reset_hdr_idx", hdr_idx, 0);
        checkOutput("reset_valids", {hdr_valid, m_valid}, 0);
        checkOutput("reset_stat_frames", stat_frames, 0);
        checkOutput("reset_stat_drops", stat_drops, 0);
        @(posedge clk); #1;

        sendFrame(8, 1, -1);
        sendFrame(8, 2, -1);
        sendFrame(2, 1, -1);
        sendFrame(8, 1, -1);
        sendFrame(10, 1, -1);
        sendFrame(8, 1, 4);
        sendFrame(8, 1, -1);
        sendFrame(3, 1, -1);
        for (int f = 0; f < 40; f++) begin
            sendFrame(int'($urandom_range(12, 1)), ($urandom_range(1) == 0) ? 0 : 2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
